// File: rtl/preg_freelist_ctrl_pkg.sv
// Shared rename-side constants and types for the physical-register free pool.
package preg_freelist_ctrl_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned CNT_W     = PREG_W + 1;
  localparam int unsigned WALK_W    = $clog2(NUM_AREGS);

  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic [1:0] {
    FL_READY,
    FL_CLEAR,
    FL_WALK
  } fl_state_t;

  // Identity map after reset: areg i owns preg i, the upper pregs are free.
  localparam logic [NUM_PREGS-1:0] RESET_MASK =
      {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};

endpackage

// File: rtl/preg_freelist_ctrl_if.sv
// Allocate/release handshake between rename/commit (master) and the free list (slave).
interface preg_freelist_ctrl_if;
  import preg_freelist_ctrl_pkg::*;

  logic  alloc_req;
  logic  alloc_grant;
  preg_t alloc_preg;
  logic  rel_valid;
  preg_t rel_preg;

  modport master (
    output alloc_req,
    output rel_valid,
    output rel_preg,
    input  alloc_grant,
    input  alloc_preg
  );

  modport slave (
    input  alloc_req,
    input  rel_valid,
    input  rel_preg,
    output alloc_grant,
    output alloc_preg
  );

endinterface

// File: rtl/lowest_set_enc.sv
// Priority encoder: index of the lowest set bit, zero when the vector is empty.
module lowest_set_enc #(
  parameter int unsigned W = 64,
  localparam int unsigned IdxW = $clog2(W)
) (
  input  logic [W-1:0]    vec_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/preg_freelist_ctrl.sv
// Physical-register free pool: one allocation per cycle, commit-time release,
// and rebuild from the committed map after a flush.
module preg_freelist_ctrl
  import preg_freelist_ctrl_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FLUSH,
  preg_freelist_ctrl_if.slave         fl,
  input  logic [NUM_AREGS*PREG_W-1:0] rrat_map,
  output logic [CNT_W-1:0]            free_count,
  output logic                        pool_empty,
  output logic                        recovering,
  output logic                        dbl_free_err
);

  logic [NUM_PREGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;
  fl_state_t            state_q, state_d;
  logic [WALK_W-1:0]    walk_q, walk_d;
  logic                 dbl_q, dbl_d;

  logic                 enc_valid;
  preg_t                enc_idx;
  logic                 grant;
  logic                 rel_new;
  preg_t [NUM_AREGS-1:0] rrat_arr;
  preg_t                walk_preg;

  lowest_set_enc #(
    .W (NUM_PREGS)
  ) u_enc (
    .vec_i   (mask_q),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  assign rrat_arr  = rrat_map;
  assign walk_preg = rrat_arr[walk_q];

  assign grant = fl.alloc_req & enc_valid & (count_q != '0) & (state_q == FL_READY) & ~FLUSH;

  assign fl.alloc_grant = grant;
  assign fl.alloc_preg  = enc_idx;
  assign free_count     = count_q;
  assign recovering     = (state_q != FL_READY);
  assign pool_empty     = recovering | (count_q == '0);
  assign dbl_free_err   = dbl_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    walk_d  = walk_q;
    dbl_d   = dbl_q;
    rel_new = 1'b0;

    unique case (state_q)
      FL_READY: begin
        if (grant) begin
          mask_d[enc_idx] = 1'b0;
        end
        if (fl.rel_valid && !FLUSH) begin
          // A release of a free preg is a double free: flag it, leave the pool alone.
          if (mask_q[fl.rel_preg]) begin
            dbl_d = 1'b1;
          end else begin
            mask_d[fl.rel_preg] = 1'b1;
            rel_new             = 1'b1;
          end
        end
        count_d = count_q + CNT_W'(rel_new) - CNT_W'(grant);
      end
      FL_CLEAR: begin
        mask_d  = '1;
        count_d = CNT_W'(NUM_PREGS);
        walk_d  = '0;
        state_d = FL_WALK;
      end
      FL_WALK: begin
        // Duplicate map entries only claim their preg once.
        if (mask_q[walk_preg]) begin
          mask_d[walk_preg] = 1'b0;
          count_d           = count_q - CNT_W'(1);
        end
        walk_d = walk_q + WALK_W'(1);
        if (walk_q == WALK_W'(NUM_AREGS - 1)) begin
          state_d = FL_READY;
        end
      end
      default: begin
        state_d = FL_READY;
      end
    endcase

    if (FLUSH) begin
      state_d = FL_CLEAR;
      walk_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_q  <= RESET_MASK;
      count_q <= CNT_W'(NUM_PREGS - NUM_AREGS);
      state_q <= FL_READY;
      walk_q  <= '0;
      dbl_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
      state_q <= state_d;
      walk_q  <= walk_d;
      dbl_q   <= dbl_d;
    end
  end

endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// Scoreboard bench: a set-based pool model predicts each cycle's outputs, a monitor compares.
module tb_preg_freelist_ctrl;
  import preg_freelist_ctrl_pkg::*;

  logic                        CLK = 1'b0;
  logic                        RESET;
  logic                        FLUSH;
  logic [NUM_AREGS*PREG_W-1:0] rrat_map;
  logic [CNT_W-1:0]            free_count;
  logic                        pool_empty;
  logic                        recovering;
  logic                        dbl_free_err;

  preg_freelist_ctrl_if fl ();

  preg_freelist_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FLUSH        (FLUSH),
    .fl           (fl),
    .rrat_map     (rrat_map),
    .free_count   (free_count),
    .pool_empty   (pool_empty),
    .recovering   (recovering),
    .dbl_free_err (dbl_free_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit rec;
    bit grant;
    int preg;
    int cnt;
    bit empty;
    bit dbl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the pool as a set of free pregs plus a recovery countdown.
  bit m_free[NUM_PREGS];
  int m_rec_left;
  bit m_dbl;
  int m_rrat[NUM_AREGS];

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("alloc_grant", int'(fl.alloc_grant), int'(e.grant));
      chk("recovering", int'(recovering), int'(e.rec));
      chk("pool_empty", int'(pool_empty), int'(e.empty));
      chk("dbl_free_err", int'(dbl_free_err), int'(e.dbl));
      if (!e.rec) begin
        chk("alloc_preg", int'(fl.alloc_preg), e.preg);
        chk("free_count", int'(free_count), e.cnt);
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_PREGS; i++) m_free[i] = (i >= NUM_AREGS);
    m_rec_left = 0;
    m_dbl      = 1'b0;
  endfunction

  task automatic step(input bit rst, input bit flush, input bit req, input bit relv,
                      input int relp, input bit push);
    exp_t e;
    int   cnt;
    int   low;
    @(posedge CLK);
    #1;
    RESET        = rst;
    FLUSH        = flush;
    fl.alloc_req = req;
    fl.rel_valid = relv;
    fl.rel_preg  = PREG_W'(relp);
    for (int i = 0; i < NUM_AREGS; i++) rrat_map[i*PREG_W +: PREG_W] = PREG_W'(m_rrat[i]);

    cnt = 0;
    low = -1;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (m_free[i]) begin
        cnt++;
        if (low < 0) low = i;
      end
    end
    e.rec   = (m_rec_left > 0);
    e.cnt   = cnt;
    e.preg  = (low < 0) ? 0 : low;
    e.empty = e.rec || (cnt == 0);
    e.grant = req && !flush && !e.rec && (cnt != 0);
    e.dbl   = m_dbl;
    if (push) q.push_back(e);

    if (rst) begin
      model_reset();
    end else if (flush) begin
      m_rec_left = NUM_AREGS + 1;
    end else if (m_rec_left > 0) begin
      m_rec_left--;
      if (m_rec_left == 0) begin
        for (int i = 0; i < NUM_PREGS; i++) m_free[i] = 1'b1;
        for (int i = 0; i < NUM_AREGS; i++) m_free[m_rrat[i]] = 1'b0;
      end
    end else begin
      if (relv) begin
        if (m_free[relp]) m_dbl = 1'b1;
        else m_free[relp] = 1'b1;
      end
      if (e.grant) m_free[low] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int r;
    int p;
    RESET        = 1'b1;
    FLUSH        = 1'b0;
    fl.alloc_req = 1'b0;
    fl.rel_valid = 1'b0;
    fl.rel_preg  = '0;
    rrat_map     = '0;
    for (int i = 0; i < NUM_AREGS; i++) m_rrat[i] = i;
    model_reset();

    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(1);

    // Four grants 32..35, then drain the rest and ask once more on an empty pool.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 29; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Release into an empty pool is not bypassed; then a grant+release in one cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1, 40, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 41, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Double free of 50.
    step(1'b0, 1'b0, 1'b0, 1'b1, 50, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 50, 1'b1);
    idle(2);

    // Recovery with areg i -> preg i+32, releases during recovery ignored.
    for (int i = 0; i < NUM_AREGS; i++) m_rrat[i] = i + NUM_AREGS;
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < NUM_AREGS + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Restart recovery when walk_idx reaches 10.
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(11);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(NUM_AREGS + 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Reset in the middle of a walk.
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(6);
    step(1'b1, 1'b0, 1'b1, 1'b1, 7, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < NUM_AREGS; i++) m_rrat[i] = i;

    // Random traffic; releases mostly target allocated pregs.
    for (int n = 0; n < 3000; n++) begin
      bit rst;
      bit flush;
      bit req;
      bit relv;
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      req   = ($urandom_range(0, 99) < 60);
      relv  = ($urandom_range(0, 99) < 45);
      p     = $urandom_range(0, NUM_PREGS - 1);
      if ($urandom_range(0, 9) != 0) begin
        for (int k = 0; k < NUM_PREGS; k++) begin
          r = (p + k) % NUM_PREGS;
          if (!m_free[r]) begin
            p = r;
            break;
          end
        end
      end
      if (m_rec_left == 0 && $urandom_range(0, 3) == 0) begin
        m_rrat[$urandom_range(0, NUM_AREGS - 1)] = $urandom_range(0, NUM_PREGS - 1);
      end
      step(rst, flush, req, relv, p, 1'b1);
    end

    idle(1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
